// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and constants for the memory arbiter slice.
//   state_e : arbiter FSM states (IDLE, RESP)
//   req_t   : one requester's transaction {addr, wdata, be, we}; addr is held
//             at the widest supported width and narrowed by the user
//   MAX_REQ : largest supported requester count; IDX_W indexes it
package mem_arb_pkg;

  localparam int MAX_REQ    = 4;
  localparam int IDX_W      = $clog2(MAX_REQ);
  localparam int ADDR_MAX_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            be;
    logic                  we;
  } req_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter -- combinational one-hot grant selection.
//   Default build: round-robin, search starts at (last_grant+1) mod NUM_REQ.
//   MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins and
//   last_grant is ignored.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    index of the most recent grant
//   grant      out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx  out IDX_W    binary index of the grant
//   any_req    out 1        at least one request is present
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  assign any_req = |req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Scan from the top down so the lowest set index is the last to overwrite.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    int   idx;
    logic found;
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one registered memory port among NUM_REQ requesters.
// One transaction every two cycles: IDLE accepts (req_ready, mem_* driven
// combinationally from the winner), RESP returns rsp_valid to that winner with
// mem_rdata for reads or zero for writes.
// Configuration macro: MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of
// the default round-robin (see rr_arbiter).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid / req_ready           per-requester handshake
//   req_addr/wdata/be/we            per-requester transaction fields
//   rsp_valid / rsp_rdata           one-cycle response strobe and shared data
//   mem_addr/wdata/be/we            memory port drive
//   mem_rdata                       memory read data, one cycle after address
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int MEM_SIZE = 8192,
  parameter  int NUM_REQ  = 2,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0]  req_wdata,
  input  logic [NUM_REQ-1:0][3:0]   req_be,
  input  logic [NUM_REQ-1:0]        req_we,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic [AW-1:0]             mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_be,
  output logic                      mem_we,
  input  logic [31:0]               mem_rdata
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 we_q;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_req;
  logic                 accept;
  req_t                 sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  assign accept = (state_q == IDLE) && any_req;

  // Winner's transaction; all zero when nobody is granted.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel.addr  = ADDR_MAX_W'(req_addr[i]);
        sel.wdata = req_wdata[i];
        sel.be    = req_be[i];
        sel.we    = req_we[i];
      end
    end
  end

  if (AW < ADDR_MAX_W) begin : g_addr_pad
    logic unused_addr_hi;
    assign unused_addr_hi = ^sel.addr[ADDR_MAX_W-1:AW];
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant bookkeeping; reset points last_grant at the top so requester 0
  // wins the first round-robin search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      we_q         <= 1'b0;
    end else if (accept) begin
      last_grant_q <= grant_idx;
      grant_q      <= grant;
      we_q         <= sel.we;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Gated with rst_n so the port is quiet while reset is held even
  // though the handshake path is combinational.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_we    = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          req_ready = grant;
          mem_addr  = sel.addr[AW-1:0];
          mem_wdata = sel.wdata;
          mem_be    = sel.be;
          mem_we    = sel.we;
        end
        RESP: begin
          rsp_valid = grant_q;
          rsp_rdata = we_q ? 32'h0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
